// File: rtl/uart_rx_frame_ctrl_if.sv
// Bus between the UART RX frame sequencer and the RX datapath (counter, oversampler, checkers, deserializer).
// Optional sticky error status is present when UART_RX_ERR_STICKY_EN is defined.
interface uart_rx_frame_ctrl_if;
  localparam int unsigned PRESCALE_W = 6;
  localparam int unsigned BIT_CNT_W  = 5;

  logic                  RX_IN;
  logic                  PAR_EN;
  logic [PRESCALE_W-1:0] Prescale;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic                  cnt_enable;
  logic                  sample_en;
  logic                  deser_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;
  logic                  busy;
`ifdef UART_RX_ERR_STICKY_EN
  logic                  err_clr;
  logic [2:0]            err_status;

  modport master (
    input  RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt, strt_glitch, par_err, stp_err, err_clr,
    output cnt_enable, sample_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, busy,
           err_status
  );
  modport slave (
    output RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt, strt_glitch, par_err, stp_err, err_clr,
    input  cnt_enable, sample_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, busy,
           err_status
  );
`else
  modport master (
    input  RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt, strt_glitch, par_err, stp_err,
    output cnt_enable, sample_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, busy
  );
  modport slave (
    output RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt, strt_glitch, par_err, stp_err,
    input  cnt_enable, sample_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, busy
  );
`endif
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame sequencer: walks start/data/parity/stop bits, strobes checkers and the deserializer.
// Define UART_RX_ERR_STICKY_EN to add sticky {stp,par,strt} error status with err_clr.
module uart_rx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_rx_frame_ctrl_if.master bus
);
  localparam int unsigned PRESCALE_W = 6;
  localparam int unsigned BIT_CNT_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_par_q;
  logic                  w_end;
  logic                  w_mid;
  logic                  w_in_bit;
  logic [PRESCALE_W-1:0] w_half;

  assign w_end    = (bus.edge_cnt == bus.Prescale);
  assign w_half   = bus.Prescale >> 1;
  assign w_mid    = (bus.edge_cnt == PRESCALE_W'(w_half - PRESCALE_W'(1))) ||
                    (bus.edge_cnt == w_half) ||
                    (bus.edge_cnt == PRESCALE_W'(w_half + PRESCALE_W'(1)));
  assign w_in_bit = (r_state == S_START) || (r_state == S_DATA) ||
                    (r_state == S_PARITY) || (r_state == S_STOP);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!bus.RX_IN) w_next = S_START;
      S_START:  if (w_end) w_next = bus.strt_glitch ? S_IDLE : S_DATA;
      S_DATA:   if (w_end && (bus.bit_cnt == BIT_CNT_W'(DATA_WIDTH)))
                  w_next = r_par_q ? S_PARITY : S_STOP;
      S_PARITY: if (w_end) w_next = bus.par_err ? S_IDLE : S_STOP;
      S_STOP:   if (w_end) w_next = bus.stp_err ? S_IDLE : S_DONE;
      S_DONE:   w_next = bus.RX_IN ? S_IDLE : S_START;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cnt_enable  = 1'b0;
    bus.sample_en   = 1'b0;
    bus.deser_en    = 1'b0;
    bus.strt_chk_en = 1'b0;
    bus.par_chk_en  = 1'b0;
    bus.stp_chk_en  = 1'b0;
    bus.data_valid  = 1'b0;
    bus.busy        = (r_state != S_IDLE);
    if (w_in_bit) begin
      bus.cnt_enable = 1'b1;
      bus.sample_en  = w_mid;
    end
    case (r_state)
      S_START:  bus.strt_chk_en = w_end;
      S_DATA:   bus.deser_en    = w_end;
      S_PARITY: bus.par_chk_en  = w_end;
      S_STOP:   bus.stp_chk_en  = w_end;
      S_DONE:   bus.data_valid  = 1'b1;
      default:  ;
    endcase
  end

  // Parity mode is frozen at frame start so mid-frame PAR_EN changes are ignored
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_par_q <= 1'b0;
    else if (((r_state == S_IDLE) || (r_state == S_DONE)) && (w_next == S_START))
      r_par_q <= bus.PAR_EN;
  end

`ifdef UART_RX_ERR_STICKY_EN
  logic [2:0] r_err_status;
  logic [2:0] w_err_set;

  assign w_err_set = {bus.stp_chk_en & bus.stp_err,
                      bus.par_chk_en & bus.par_err,
                      bus.strt_chk_en & bus.strt_glitch};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)             r_err_status <= 3'b000;
    else if (bus.err_clr) r_err_status <= 3'b000;
    else                  r_err_status <= r_err_status | w_err_set;
  end

  assign bus.err_status = r_err_status;
`endif
endmodule
